// File: rtl/program_mem_loadable_if.sv
// -----------------------------------------------------------------------------
// program_mem_loadable_if
// Bundles the fetch port and the byte-loader handshake of program_mem_loadable.
//   master : the core/loader side (drives pc, load_en, ld_data, ld_valid)
//   slave  : the program memory (drives ir, ld_ready, cpu_hold, ld_err, word_cnt)
// Signals:
//   pc        fetch address
//   ir        registered instruction word
//   load_en   level request for load mode
//   ld_data   loader byte
//   ld_valid  ld_data is valid
//   ld_ready  memory accepts a byte this cycle
//   cpu_hold  core must stall while high
//   ld_err    sticky loader error flag
//   word_cnt  words written in the current or last load
// -----------------------------------------------------------------------------
interface program_mem_loadable_if #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16
);
    logic [PC_WIDTH-1:0] pc;
    logic [IR_WIDTH-1:0] ir;
    logic                load_en;
    logic [7:0]          ld_data;
    logic                ld_valid;
    logic                ld_ready;
    logic                cpu_hold;
    logic                ld_err;
    logic [PC_WIDTH:0]   word_cnt;

    modport master (
        output pc, load_en, ld_data, ld_valid,
        input  ir, ld_ready, cpu_hold, ld_err, word_cnt
    );

    modport slave (
        input  pc, load_en, ld_data, ld_valid,
        output ir, ld_ready, cpu_hold, ld_err, word_cnt
    );
endinterface

// File: rtl/program_mem_loadable.sv
// -----------------------------------------------------------------------------
// program_mem_loadable
// Instruction memory that can be reloaded byte-by-byte from a loader stream.
// In RUN the memory is fetched at pc with one cycle of latency; in LOAD the
// core is held, ir reads as NOP, and bytes are assembled MSB-first into words
// written at successive addresses starting from 0.
// Ports:
//   clk    rising-edge clock
//   res_n  asynchronous active-low reset (also clears the whole memory)
//   bus    program_mem_loadable_if.slave (fetch port + loader handshake)
// -----------------------------------------------------------------------------
module program_mem_loadable #(
    parameter int PC_WIDTH = 8,
    parameter int IR_WIDTH = 16,   // multiple of 8
    parameter int CMD_CNT  = 64    // at most 2**PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   res_n,
    program_mem_loadable_if.slave  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    localparam int BYTES = IR_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int AW    = (CMD_CNT > 1) ? $clog2(CMD_CNT) : 1;
    localparam logic [BCW-1:0]    LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [PC_WIDTH:0] CMD_CNT_W = (PC_WIDTH + 1)'(CMD_CNT);

    state_e              state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                ld_ready_q, ld_ready_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                ld_err_q, ld_err_d;
    // word_cnt also serves as the write address: both clear on LOAD entry and
    // advance together, and both stop once the memory is full.
    logic [PC_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [IR_WIDTH-1:0] asm_q, asm_d;   // partial word being assembled
    logic [IR_WIDTH-1:0] mem_q [CMD_CNT];
    logic [IR_WIDTH-1:0] mem_d [CMD_CNT];

    // NOTE: every signal gets a default at the top of always_comb so that no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d    = state_q;
        ir_d       = '0;
        ld_err_d   = ld_err_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        mem_d      = mem_q;

        case (state_q)
            ST_RUN: begin
                if (bus.load_en) begin
                    state_d    = ST_LOAD;
                    ld_err_d   = 1'b0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    asm_d      = '0;
                end
            end
            ST_LOAD: begin
                if (!bus.load_en) begin
                    // Leaving with a partial word: drop its bytes and flag it.
                    state_d    = ST_RUN;
                    byte_cnt_d = '0;
                    if (byte_cnt_q != '0) ld_err_d = 1'b1;
                end else if (bus.ld_valid) begin
                    asm_d = IR_WIDTH'({asm_q, bus.ld_data});
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        if (word_cnt_q < CMD_CNT_W) begin
                            mem_d[word_cnt_q[AW-1:0]] = asm_d;
                            word_cnt_d = word_cnt_q + 1'b1;
                        end else begin
                            // Full: drop the word rather than wrap onto word 0.
                            ld_err_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        ld_ready_d = (state_d == ST_LOAD);
        // Hold stays up for one extra cycle after LOAD so the core first sees
        // an ir fetched from the freshly loaded image.
        cpu_hold_d = (state_d == ST_LOAD) || (state_q == ST_LOAD);

        // The fetch on the LOAD->RUN edge reads the finished image: no byte is
        // accepted on that edge, so mem_q is final.
        if (state_d == ST_RUN && {1'b0, bus.pc} < CMD_CNT_W) begin
            ir_d = mem_q[bus.pc[AW-1:0]];
        end
    end

    // NOTE: the memory array sits in the async-reset block on purpose: reset
    // must leave every word as NOP, including after an aborted load.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= ST_RUN;
            ir_q       <= '0;
            ld_ready_q <= 1'b0;
            cpu_hold_q <= 1'b0;
            ld_err_q   <= 1'b0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ld_ready_q <= ld_ready_d;
            cpu_hold_q <= cpu_hold_d;
            ld_err_q   <= ld_err_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.ir       = ir_q;
    assign bus.ld_ready = ld_ready_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.ld_err   = ld_err_q;
    assign bus.word_cnt = word_cnt_q;

endmodule

// File: tb/tb_program_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_program_mem_loadable
// Self-checking bench for program_mem_loadable. A reference image of the
// memory is kept alongside the byte stream; fetch expectations are queued when
// pc is driven and compared when ir appears one cycle later.
// -----------------------------------------------------------------------------
module tb_program_mem_loadable;

    localparam int PC_W = 8;
    localparam int IR_W = 16;
    localparam int CMD  = 64;

    logic clk   = 1'b0;
    logic res_n = 1'b0;

    always #5 clk = ~clk;

    program_mem_loadable_if #(.PC_WIDTH(PC_W), .IR_WIDTH(IR_W)) bus ();

    program_mem_loadable #(
        .PC_WIDTH(PC_W),
        .IR_WIDTH(IR_W),
        .CMD_CNT (CMD)
    ) dut (
        .clk  (clk),
        .res_n(res_n),
        .bus  (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [IR_W-1:0] model_mem [CMD];
    int              model_cnt;
    logic            model_err;
    logic [IR_W-1:0] model_acc;
    int              model_nb;
    logic [IR_W-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (model_mem[i]) model_mem[i] = '0;
        model_cnt = 0;
        model_err = 1'b0;
        model_acc = '0;
        model_nb  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ir"},    bus.ir,       0);
        check({tag, "_ready"}, bus.ld_ready, 0);
        check({tag, "_hold"},  bus.cpu_hold, 0);
        check({tag, "_err"},   bus.ld_err,   0);
        check({tag, "_wcnt"},  bus.word_cnt, 0);
    endtask

    task automatic start_load();
        bus.load_en  = 1'b1;
        bus.ld_valid = 1'b0;
        @(negedge clk);
        model_cnt = 0;
        model_err = 1'b0;
        model_nb  = 0;
        model_acc = '0;
        check("load_ready", bus.ld_ready, 1);
        check("load_hold",  bus.cpu_hold, 1);
        check("load_ir",    bus.ir,       0);
        check("load_wcnt",  bus.word_cnt, 0);
        check("load_err",   bus.ld_err,   0);
    endtask

    // One accepted byte; with gap set, an idle cycle with ld_valid=0 and
    // junk data follows.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bus.ld_data  = b;
        bus.ld_valid = 1'b1;
        @(negedge clk);
        model_acc = (model_acc << 8) | IR_W'(b);
        model_nb++;
        if (model_nb == IR_W / 8) begin
            model_nb = 0;
            if (model_cnt < CMD) begin
                model_mem[model_cnt] = model_acc;
                model_cnt++;
            end else begin
                model_err = 1'b1;
            end
        end
        bus.ld_valid = 1'b0;
        if (gap) begin
            bus.ld_data = ~b;
            @(negedge clk);
        end
    endtask

    task automatic end_load();
        bus.load_en = 1'b0;
        bus.pc      = '0;
        @(negedge clk);
        if (model_nb != 0) model_err = 1'b1;
        model_nb = 0;
        check("exit_hold",  bus.cpu_hold, 1);
        check("exit_ready", bus.ld_ready, 0);
        check("exit_ir",    bus.ir,       model_mem[0]);
        check("exit_wcnt",  bus.word_cnt, model_cnt);
        check("exit_err",   bus.ld_err,   model_err);
        @(negedge clk);
        check("run_hold",   bus.cpu_hold, 0);
    endtask

    task automatic fetch(input int a);
        bus.pc = PC_W'(a);
        exp_q.push_back((a < CMD) ? model_mem[a] : '0);
        @(negedge clk);
        check($sformatf("ir_pc%0d", a), bus.ir, exp_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pc       = '0;
        bus.load_en  = 1'b0;
        bus.ld_data  = '0;
        bus.ld_valid = 1'b0;
        model_reset();

        // Reset state, then a fetch in RUN returns NOP and no hold.
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        res_n = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hA5;
        repeat (3) @(negedge clk);
        bus.ld_valid = 1'b0;
        check("run_ready", bus.ld_ready, 0);
        check("run_wcnt",  bus.word_cnt, 0);
        fetch(5);
        check("run_hold0", bus.cpu_hold, 0);
        fetch(0);

        // Basic two-word load.
        start_load();
        send_byte(8'h49, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h4A, 1'b0);
        send_byte(8'h14, 1'b0);
        end_load();
        check("basic_wcnt", bus.word_cnt, 2);
        check("basic_err",  bus.ld_err,   0);
        fetch(0);
        check("basic_w0", bus.ir, 16'h4903);
        fetch(1);
        check("basic_w1", bus.ir, 16'h4A14);

        // ld_valid toggling: only valid cycles consume bytes.
        start_load();
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1'b1);
        end_load();
        for (int i = 0; i < 7; i++) fetch(i);
        fetch(CMD - 1);
        fetch(CMD);
        fetch(200);

        // Partial word at exit is discarded and flagged.
        bus.pc = '0;
        #2 res_n = 1'b0;
        #1 check_reset_outputs("rst2");
        @(negedge clk);
        res_n = 1'b1;
        model_reset();
        start_load();
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        end_load();
        check("part_wcnt", bus.word_cnt, 1);
        check("part_err",  bus.ld_err,   1);
        fetch(0);
        fetch(1);
        check("part_w1_zero", bus.ir, 0);

        // Overflow: CMD_CNT+1 words, the last one dropped without wrapping.
        start_load();
        for (int i = 0; i < 2 * CMD; i++) send_byte(8'($urandom), 1'b0);
        check("full_wcnt", bus.word_cnt, CMD);
        check("full_err",  bus.ld_err,   0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        check("ovf_wcnt", bus.word_cnt, CMD);
        check("ovf_err",  bus.ld_err,   1);
        end_load();
        for (int i = 0; i < CMD; i++) fetch(i);
        repeat (3) @(negedge clk);
        check("hold_err",  bus.ld_err,   1);
        check("hold_wcnt", bus.word_cnt, CMD);

        // Reset mid-LOAD after word 0 is written, with a byte pending.
        start_load();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        #2 res_n = 1'b0;
        #1 check_reset_outputs("rst3");
        bus.load_en = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
        model_reset();
        for (int i = 0; i < CMD; i++) fetch(i);

        // Reset released with load_en already high: first edge enters LOAD.
        #2 res_n = 1'b0;
        bus.load_en = 1'b1;
        @(negedge clk);
        res_n = 1'b1;
        @(negedge clk);
        check("rel_ready", bus.ld_ready, 1);
        check("rel_hold",  bus.cpu_hold, 1);
        end_load();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_mem_loadable.md
PROGRAM_MEM_LOADABLE -- requirements
Module: program_mem_loadable

Interface
REQ-001 Parameter PC_WIDTH, default 8, SHALL set the width of the fetch address.
REQ-002 Parameter IR_WIDTH, default 16, SHALL set the instruction word width, and SHALL be a multiple of 8.
REQ-003 Parameter CMD_CNT, default 64, SHALL set the number of words, and SHALL be at most 2^PC_WIDTH.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port res_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port pc, input, PC_WIDTH bits: fetch address.
REQ-007 Port ir, output, IR_WIDTH bits: registered instruction word.
REQ-008 Port load_en, input, 1 bit: level request for load mode.
REQ-009 Port ld_data, input, 8 bits: loader byte.
REQ-010 Port ld_valid, input, 1 bit: ld_data is valid.
REQ-011 Port ld_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-012 Port cpu_hold, output, 1 bit: the core SHALL stall while this is 1.
REQ-013 Port ld_err, output, 1 bit: sticky loader error flag.
REQ-014 Port word_cnt, output, PC_WIDTH+1 bits: number of words written in the current or last load.

Function
REQ-015 The block SHALL have two states, RUN and LOAD.
REQ-016 RUN to LOAD SHALL occur on the first clock edge with load_en=1.
REQ-017 LOAD to RUN SHALL occur on the first clock edge with load_en=0.
REQ-018 On entering LOAD, the write address, the byte counter and word_cnt SHALL clear to 0, and ld_err SHALL clear.
REQ-019 ld_ready SHALL be 1 exactly while in LOAD; it SHALL be 0 in RUN and during reset.
REQ-020 A byte SHALL be accepted on a clock edge only when ld_valid=1 and ld_ready=1; in RUN, ld_valid SHALL be ignored.
REQ-021 Bytes SHALL assemble MSB-first; IR_WIDTH/8 accepted bytes SHALL form one word.
REQ-022 The completed word SHALL be written on the edge that accepts its last byte; the write address and word_cnt SHALL then increment by 1.
REQ-023 A completed word with write address >= CMD_CNT SHALL be dropped (no wrap-around) and SHALL set ld_err.
REQ-024 While over range, word_cnt SHALL hold at CMD_CNT.
REQ-025 When load_en falls with a partial word pending, those bytes SHALL be discarded and ld_err SHALL be set.
REQ-026 In RUN, ir SHALL update each edge to mem[pc], giving 1-cycle latency.
REQ-027 In RUN, pc >= CMD_CNT SHALL yield ir=0 (NOP).
REQ-028 In LOAD, ir SHALL be 0.
REQ-029 cpu_hold SHALL be 1 in LOAD.
REQ-030 cpu_hold SHALL also be 1 for the first RUN cycle after LOAD, so that ir reflects the new image before the core resumes.
REQ-031 A fetch SHALL never observe a word mid-write; reads and writes never coincide because the two states are exclusive.
REQ-032 ld_err and word_cnt SHALL hold their values in RUN until the next LOAD entry.

Reset
REQ-033 With res_n=0, asynchronously: state=RUN, ir=0, ld_ready=0, cpu_hold=0, ld_err=0, word_cnt=0, byte counter=0, write address=0.
REQ-034 Reset SHALL clear all CMD_CNT words to 0 (NOP).
REQ-035 Reset asserted mid-LOAD SHALL abort the load, discard any partial word, and leave memory all-zero.
REQ-036 After reset release, the first edge SHALL behave as RUN unless load_en=1.

Verification
REQ-037 Reset, then pc=5 in RUN -> ir=0 one cycle later; cpu_hold=0.
REQ-038 Defaults; load_en=1; bytes 49,03,4A,14 with ld_valid continuous; load_en=0; pc=0 then pc=1 -> word_cnt=2, ld_err=0, ir=16'h4903 then 16'h4A14; cpu_hold=1 for exactly one cycle after leaving LOAD.
REQ-039 Load 2*CMD_CNT+2 bytes (CMD_CNT+1 words) -> word_cnt=CMD_CNT, ld_err=1, words 0..CMD_CNT-1 hold the loaded data, no overwrite of word 0.
REQ-040 Load 3 bytes then drop load_en -> word_cnt=1, ld_err=1, word 1 remains 0.
REQ-041 ld_valid toggling every other cycle during a load -> only cycles with ld_valid=1 consume bytes; image correct; pc=200 in RUN -> ir=0.
REQ-042 Assert res_n=0 mid-LOAD after word 0 is written -> all outputs at reset values, mem[0] reads 0 after release.
